// File: rtl/dram_pkg.sv
// Shared encodings for the data-memory access path. The size codes mirror
// the instruction decoder's dram_we / store_sel / wd_dram_sel outputs.
package dram_pkg;

    localparam logic [1:0] STORE_SW = 2'b00;
    localparam logic [1:0] STORE_SH = 2'b01;
    localparam logic [1:0] STORE_SB = 2'b10;

    localparam logic [2:0] LOAD_LW  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LB  = 3'b010;
    localparam logic [2:0] LOAD_LHU = 3'b011;
    localparam logic [2:0] LOAD_LBU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } dram_state_e;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } acc_size_e;

    // Unused codes (sw 11, loads 101-111) fall back to a word access.
    function automatic acc_size_e access_size(input logic       we,
                                              input logic [1:0] store_sel,
                                              input logic [2:0] load_sel);
        acc_size_e sz;
        sz = SZ_WORD;
        if (we) begin
            case (store_sel)
                STORE_SH: sz = SZ_HALF;
                STORE_SB: sz = SZ_BYTE;
                default:  sz = SZ_WORD;
            endcase
        end else begin
            case (load_sel)
                LOAD_LH, LOAD_LHU: sz = SZ_HALF;
                LOAD_LB, LOAD_LBU: sz = SZ_BYTE;
                default:           sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_aligned(input acc_size_e sz, input logic [1:0] addr_lo);
        logic ok;
        case (sz)
            SZ_WORD: ok = (addr_lo == 2'b00);
            SZ_HALF: ok = ~addr_lo[0];
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dram_lane_align.sv
// Byte-lane steering: builds byte enables and replicated store data, and
// extracts/extends the addressed lane of a read word.
module dram_lane_align
    import dram_pkg::*;
(
    input  acc_size_e   size,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  load_sel,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Byte enables and lane-replicated write data from access size and offset.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        case (size)
            SZ_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed lane of the read word and sign/zero extend it.
    always_comb begin
        case (addr_lo)
            2'd1:    byte_lane = rdata_word[15:8];
            2'd2:    byte_lane = rdata_word[23:16];
            2'd3:    byte_lane = rdata_word[31:24];
            default: byte_lane = rdata_word[7:0];
        endcase
        half_lane = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];
        case (load_sel)
            LOAD_LH:  rdata_ext = {{16{half_lane[15]}}, half_lane};
            LOAD_LHU: rdata_ext = {16'h0000, half_lane};
            LOAD_LB:  rdata_ext = {{24{byte_lane[7]}}, byte_lane};
            LOAD_LBU: rdata_ext = {24'h000000, byte_lane};
            default:  rdata_ext = rdata_word;
        endcase
    end

endmodule

// File: rtl/dram_access_unit.sv
// Multi-cycle data-memory access unit: captures a core load/store, runs a
// req/ack handshake with a wait-state bus, and stalls the core until done.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for req_valid; misaligned requests pulse misalign here
// BUS     | mem_req out, waiting for mem_ack or the wait-counter limit
// RESP    | done pulse, core retires the instruction; always back to IDLE
module dram_access_unit
    import dram_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_store_sel,
    input  logic [2:0]  req_load_sel,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_TC = CW'(MAX_WAIT);

    dram_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          misalign_q, misalign_d;
    logic          bus_err_q, bus_err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [1:0]    ssel_q, ssel_d;
    logic [2:0]    lsel_q, lsel_d;

    logic          req_ok;
    logic          in_bus;
    acc_size_e     cap_size;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata;
    logic [31:0]   lane_rdata;

    assign req_ok   = is_aligned(access_size(req_we, req_store_sel, req_load_sel), req_addr[1:0]);
    assign cap_size = access_size(we_q, ssel_q, lsel_q);
    assign in_bus   = (state_q == ST_BUS);

    dram_lane_align u_lane (
        .size       (cap_size),
        .addr_lo    (addr_q[1:0]),
        .load_sel   (lsel_q),
        .wdata      (wdata_q),
        .rdata_word (mem_rdata),
        .be         (lane_be),
        .wdata_rep  (lane_wdata),
        .rdata_ext  (lane_rdata)
    );

    // Next-state, wait counter, request capture and response latching.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_req_d  = 1'b0;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        ssel_d     = ssel_q;
        lsel_d     = lsel_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    if (req_ok) begin
                        addr_d    = req_addr;
                        wdata_d   = req_wdata;
                        we_d      = req_we;
                        ssel_d    = req_store_sel;
                        lsel_d    = req_load_sel;
                        mem_req_d = (WAIT_TC != '0);
                        state_d   = ST_BUS;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end
            ST_BUS: begin
                if (mem_ack) begin
                    rdata_d = we_q ? 32'h0 : lane_rdata;
                    state_d = ST_RESP;
                end else if (cnt_q == WAIT_TC) begin
                    bus_err_d = 1'b1;
                    rdata_d   = 32'h0;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    // Request is withdrawn for the final timeout cycle.
                    mem_req_d = (cnt_d != WAIT_TC);
                end
            end
            ST_RESP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            rdata_q    <= 32'h0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            we_q       <= 1'b0;
            ssel_q     <= STORE_SW;
            lsel_q     <= LOAD_LW;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            ssel_q     <= ssel_d;
            lsel_q     <= lsel_d;
        end
    end

    // Bus-side outputs are only driven while an access is in flight.
    always_comb begin
        stall     = (state_q == ST_IDLE && req_valid && req_ok) || in_bus;
        done      = (state_q == ST_RESP);
        misalign  = misalign_q;
        bus_err   = bus_err_q;
        rdata     = rdata_q;
        mem_req   = mem_req_q;
        mem_we    = in_bus & we_q;
        mem_addr  = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_be    = in_bus ? lane_be : 4'b0000;
        mem_wdata = (in_bus && we_q) ? lane_wdata : 32'h0;
    end

endmodule

// File: tb/tb_dram_access_unit.sv
// Scoreboard bench for dram_access_unit (MAX_WAIT = 4): stimulus queues the
// expected bus beat and response, monitors compare when the DUT presents them.
module tb_dram_access_unit;
    import dram_pkg::*;

    localparam int TB_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [1:0]  req_store_sel;
    logic [2:0]  req_load_sel;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, misalign, bus_err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    dram_access_unit #(.MAX_WAIT(TB_MAX)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_store_sel (req_store_sel),
        .req_load_sel  (req_load_sel),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .stall         (stall),
        .rdata         (rdata),
        .done          (done),
        .misalign      (misalign),
        .bus_err       (bus_err),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        bit          is_mis;
        int          cyc;
        logic [31:0] rdata;
        logic        bus_err;
        int          stall_n;
        int          req_n;
    } resp_t;

    typedef struct {
        string       tag;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    resp_t rq[$];
    bus_t  bq[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: bus beats and done/misalign events against the queues.
    initial begin : monitor
        bus_t  cur;
        resp_t e;
        int    stall_n = 0;
        int    req_n   = 0;
        bit    req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_n  = 0;
                req_n    = 0;
                req_prev = 1'b0;
            end else begin
                if (stall)   stall_n++;
                if (mem_req) req_n++;
                if (mem_req && !req_prev) begin
                    if (bq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_mem_req at cycle %0d", cyc);
                    end else begin
                        cur = bq.pop_front();
                        chk({cur.tag, ".mem_we"},    {31'b0, mem_we}, {31'b0, cur.we});
                        chk({cur.tag, ".mem_addr"},  mem_addr, cur.addr);
                        chk({cur.tag, ".mem_be"},    {28'b0, mem_be}, {28'b0, cur.be});
                        chk({cur.tag, ".mem_wdata"}, mem_wdata, cur.wdata);
                    end
                end else if (mem_req) begin
                    chk({cur.tag, ".hold_addr"},  mem_addr, cur.addr);
                    chk({cur.tag, ".hold_wdata"}, mem_wdata, cur.wdata);
                end
                req_prev = mem_req;
                if (done || misalign) begin
                    if (rq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_event done=%0b misalign=%0b at cycle %0d", done, misalign, cyc);
                    end else begin
                        e = rq.pop_front();
                        chk({e.tag, ".misalign"}, {31'b0, misalign}, {31'b0, e.is_mis});
                        chk({e.tag, ".done"},     {31'b0, done},     {31'b0, !e.is_mis});
                        chk({e.tag, ".cycle"},    cyc, e.cyc);
                        if (!e.is_mis) chk({e.tag, ".rdata"}, rdata, e.rdata);
                        chk({e.tag, ".bus_err"},  {31'b0, bus_err}, {31'b0, e.bus_err});
                        chk({e.tag, ".stall_cycles"}, stall_n, e.stall_n);
                        chk({e.tag, ".req_cycles"},   req_n, e.req_n);
                    end
                    stall_n = 0;
                    req_n   = 0;
                end
            end
        end
    end

    // Issue one access starting in the current cycle; returns in the next IDLE cycle.
    task automatic access(input string tag, input bit we, input logic [1:0] ssel,
                          input logic [2:0] lsel, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rd,
                          input int waits, input bit ack_en, input bit exp_mis,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                          input bit exp_err, input int exp_done, input int exp_stall,
                          input int exp_req);
        resp_t r;
        bus_t  b;
        int    nb;
        r.tag = tag; r.is_mis = exp_mis; r.cyc = cyc + exp_done; r.rdata = exp_rdata;
        r.bus_err = exp_err; r.stall_n = exp_stall; r.req_n = exp_req;
        rq.push_back(r);
        if (!exp_mis) begin
            b.tag = tag; b.we = we; b.addr = exp_addr; b.be = exp_be; b.wdata = exp_wdata;
            bq.push_back(b);
        end
        req_valid = 1'b1; req_we = we; req_store_sel = ssel; req_load_sel = lsel;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (exp_mis) begin
            @(posedge clk); #1;
        end else begin
            nb = ack_en ? waits + 1 : TB_MAX + 1;
            for (int i = 0; i < nb; i++) begin
                if (ack_en && i == waits) begin
                    mem_ack = 1'b1; mem_rdata = rd;
                end
                @(posedge clk); #1;
                mem_ack = 1'b0; mem_rdata = 32'h0;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".stall"},     {31'b0, stall},    0);
        chk({tag, ".done"},      {31'b0, done},     0);
        chk({tag, ".misalign"},  {31'b0, misalign}, 0);
        chk({tag, ".bus_err"},   {31'b0, bus_err},  0);
        chk({tag, ".mem_req"},   {31'b0, mem_req},  0);
        chk({tag, ".mem_we"},    {31'b0, mem_we},   0);
        chk({tag, ".mem_be"},    {28'b0, mem_be},   0);
        chk({tag, ".mem_addr"},  mem_addr,  0);
        chk({tag, ".mem_wdata"}, mem_wdata, 0);
        chk({tag, ".rdata"},     rdata,     0);
        chk({tag, ".state"},     {30'b0, u_dut.state_q}, {30'b0, ST_IDLE});
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_store_sel = 2'b00;
        req_load_sel = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        //      tag         we ssel   lsel    addr          wdata         rd            w  ack mis exp_addr      be       exp_wdata     exp_rdata     err done stl req
        access("sb_1003",   1, 2'b10, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 1, 0, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0,         0, 2, 2, 1);
        access("lb_2002",   0, 2'b00, 3'b010, 32'h0000_2002, 32'h1122_3344, 32'h0080_0000, 0, 1, 0, 32'h0000_2000, 4'b0100, 32'h0,         32'hFFFF_FF80, 0, 2, 2, 1);
        access("lbu_2002",  0, 2'b00, 3'b100, 32'h0000_2002, 32'h0,         32'h0080_0000, 0, 1, 0, 32'h0000_2000, 4'b0100, 32'h0,         32'h0000_0080, 0, 2, 2, 1);
        access("lh_mis",    0, 2'b00, 3'b001, 32'h0000_2001, 32'h0,         32'h0,         0, 1, 1, 32'h0,         4'b0000, 32'h0,         32'h0,         0, 1, 0, 0);
        access("lw_wait3",  0, 2'b00, 3'b000, 32'h0000_2004, 32'h0,         32'hDEAD_BEEF, 3, 1, 0, 32'h0000_2004, 4'b1111, 32'h0,         32'hDEAD_BEEF, 0, 5, 5, 4);
        access("lw_tmo",    0, 2'b00, 3'b000, 32'h0000_2008, 32'h0,         32'h0,         0, 0, 0, 32'h0000_2008, 4'b1111, 32'h0,         32'h0,         1, 6, 6, 4);
        access("lw_ack_tc", 0, 2'b00, 3'b000, 32'h0000_200C, 32'h0,         32'h0BAD_F00D, 4, 1, 0, 32'h0000_200C, 4'b1111, 32'h0,         32'h0BAD_F00D, 0, 6, 6, 4);
        access("sh_1002",   1, 2'b01, 3'b000, 32'h0000_1002, 32'hCAFE_1234, 32'h0,         1, 1, 0, 32'h0000_1000, 4'b1100, 32'h1234_1234, 32'h0,         0, 3, 3, 2);
        access("sw_code11", 1, 2'b11, 3'b000, 32'h0000_1008, 32'h89AB_CDEF, 32'h0,         0, 1, 0, 32'h0000_1008, 4'b1111, 32'h89AB_CDEF, 32'h0,         0, 2, 2, 1);
        access("lh_2002",   0, 2'b00, 3'b001, 32'h0000_2002, 32'h0,         32'h8001_7F00, 0, 1, 0, 32'h0000_2000, 4'b1100, 32'h0,         32'hFFFF_8001, 0, 2, 2, 1);
        access("lhu_2000",  0, 2'b00, 3'b011, 32'h0000_2000, 32'h0,         32'h1234_8001, 0, 1, 0, 32'h0000_2000, 4'b0011, 32'h0,         32'h0000_8001, 0, 2, 2, 1);
        access("lb_2001",   0, 2'b00, 3'b010, 32'h0000_2001, 32'h0,         32'h1234_F678, 2, 1, 0, 32'h0000_2000, 4'b0010, 32'h0,         32'hFFFF_FFF6, 0, 4, 4, 3);
        access("sw_mis",    1, 2'b00, 3'b000, 32'h0000_1002, 32'h1,         32'h0,         0, 1, 1, 32'h0,         4'b0000, 32'h0,         32'h0,         0, 1, 0, 0);
        access("lw_mis_c5", 0, 2'b00, 3'b101, 32'h0000_2012, 32'h0,         32'h0,         0, 1, 1, 32'h0,         4'b0000, 32'h0,         32'h0,         0, 1, 0, 0);
        access("sb_1001",   1, 2'b10, 3'b000, 32'h0000_1001, 32'h0000_005A, 32'h0,         0, 1, 0, 32'h0000_1000, 4'b0010, 32'h5A5A_5A5A, 32'h0,         0, 2, 2, 1);
        access("lw_code5",  0, 2'b00, 3'b101, 32'h0000_2010, 32'h0,         32'h8000_0001, 0, 1, 0, 32'h0000_2010, 4'b1111, 32'h0,         32'h8000_0001, 0, 2, 2, 1);

        // Reset in the second BUS cycle with mem_ack high: no done may follow.
        bq.push_back('{tag: "rst_mid", we: 1'b0, addr: 32'h0000_3000, be: 4'b1111, wdata: 32'h0});
        req_valid = 1'b1; req_we = 1'b0; req_load_sel = 3'b000; req_addr = 32'h0000_3000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        @(posedge clk); #1;
        rst = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        chk_all_zero("rst_mid");
        repeat (4) @(posedge clk);
        #1;

        access("sb_after",  1, 2'b10, 3'b000, 32'h0000_1002, 32'h0000_00C3, 32'h0,         0, 1, 0, 32'h0000_1000, 4'b0100, 32'hC3C3_C3C3, 32'h0,         0, 2, 2, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("resp_queue_drained", rq.size(), 0);
        chk("bus_queue_drained",  bq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_access_unit.md
# dram_access_unit

Sequential memory-access unit between the single-cycle core's decoded memory controls (`dram_we`, `store_sel`, `wd_dram_sel`) and a wait-state data-memory bus. It consumes the decoded store/load size codes, builds byte enables and replicated write data, and runs a request/acknowledge handshake with the memory. It returns sign- or zero-extended load data and stalls the core until the access completes, faults on misalignment, or times out.

## Interface
- `MAX_WAIT`, default 255: maximum BUS-state cycles without `mem_ack` before a bus error.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req_valid` in 1: current instruction is a load or store.
- `req_we` in 1: 1 = store, 0 = load (driven from `dram_we`).
- `req_store_sel` in 2: 00 sw, 01 sh, 10 sb; 11 treated as sw.
- `req_load_sel` in 3: 000 lw, 001 lh, 010 lb, 011 lhu, 100 lbu; 101–111 treated as lw.
- `req_addr` in 32: byte address from the ALU.
- `req_wdata` in 32: rs2 value.
- `stall` out 1: hold PC and register-file write.
- `rdata` out 32: extended load result, valid while `done`=1.
- `done` out 1: one-cycle completion pulse.
- `misalign` out 1: one-cycle fault pulse; no bus access is made.
- `bus_err` out 1: one-cycle timeout pulse, coincident with `done`.
- `mem_req` out 1: bus request, registered.
- `mem_we` out 1: bus write strobe.
- `mem_addr` out 32: word-aligned address, `{req_addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated write data.
- `mem_ack` in 1: memory completion, sampled only in BUS.
- `mem_rdata` in 32: read word, valid with `mem_ack`.

## Operation
- FSM has three states: IDLE, BUS, RESP.
- **IDLE**
  - `req_valid` with an aligned request: capture address, size code, write data and we; go to BUS.
  - `req_valid` with a misaligned request: pulse `misalign` next cycle and stay in IDLE.
  - Alignment rules: a word access faults if `addr[1:0]`≠0; a half access faults if `addr[0]`≠0; a byte access never faults.
- **BUS**
  - `mem_req`=1. `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` stay stable from the captured values.
  - The wait counter increments each cycle.
  - On `mem_ack`: latch the extended `mem_rdata` (loads only), then go to RESP.
  - On counter = `MAX_WAIT` with no ack: drop `mem_req`, set `bus_err`, force `rdata`=0, then go to RESP.
- **RESP**
  - `done`=1 and `stall`=0; the core retires the instruction at the end of this cycle.
  - Always returns to IDLE. `req_valid` is ignored in RESP.
- **Byte enables**
  - sb: `be = 4'b0001 << addr[1:0]`, `wdata = {4{wdata[7:0]}}`.
  - sh: `be = addr[1] ? 1100 : 0011`, `wdata = {2{wdata[15:0]}}`.
  - sw: `be = 1111`.
  - Loads use the same `be` rule as stores of the same size.
- **Load extract**: select the byte or half lane by `addr[1:0]`. lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend.
- **Stores**: `rdata`=0.
- **Reset values**: state IDLE, counter 0. All outputs are 0: `stall`, `done`, `misalign`, `bus_err`, `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `rdata`.
- **Reset mid-access**: at the reset edge the unit returns to IDLE and drops `mem_req`, even if `mem_ack` is asserted in that cycle. No `done` is issued.

## Timing
- `stall` is combinational: `(IDLE & req_valid & aligned) | BUS`. A misaligned request never stalls.
- Zero-wait memory (ack in the first BUS cycle):
  - cycle 0: IDLE, request accepted.
  - cycle 1: BUS, `mem_req`=1, ack seen.
  - cycle 2: RESP, `done`.
  - Total latency is 2 cycles; `stall` is high in cycles 0–1.
- N wait cycles: `done` arrives at cycle 2+N.
- Timeout: `bus_err`/`done` at cycle `MAX_WAIT`+2.
- `misalign` pulses in the cycle after the request, while in IDLE. The core must deassert `req_valid` or trap in that cycle.
- `mem_ack` outside BUS is ignored. An ack in the same cycle the counter reaches `MAX_WAIT` counts as success.
- Back-to-back: a new request is accepted the cycle after RESP.

## Structure
- Shared package `dram_pkg`:
  - store-size codes (`STORE_SW/SH/SB`);
  - load codes (`LOAD_LW/LH/LB/LHU/LBU`);
  - FSM state enum.
- These codes must match the decoder's encodings.
- One combinational sub-module, `dram_lane_align`, holds the `be`/`wdata` build and the `rdata` extract/extend. It is instantiated once; the FSM, counter and capture registers stay in the top.

## Test plan
- Store sb, addr 0x1003, wdata 0x000000A5, ack on first BUS cycle -> `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `mem_addr`=0x1000, `done` at cycle 2.
- Load lb, addr 0x2002, `mem_rdata`=0x0080_0000 -> `rdata`=0xFFFFFF80. Same access as lbu -> `rdata`=0x00000080.
- Load lh at addr 0x2001 -> `misalign` pulse, `mem_req` never asserted, `stall` stays 0.
- Load lw, ack after 3 wait cycles, `mem_rdata`=0xDEADBEEF -> `stall` high 5 cycles, `done` at cycle 5, `rdata`=0xDEADBEEF.
- `MAX_WAIT`=4, no ack -> `mem_req` high for cycles 1–4, `bus_err`=`done`=1 at cycle 6, `rdata`=0.
- `rst` asserted in the second BUS cycle while `mem_ack`=1 -> next cycle all outputs are 0, state is IDLE, and `done` never pulses.
